// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundles the ID-side request, WB bypass, stall/flush control
// and EX-side results of the ID/EX pipeline register.
//   master : upstream driver (decode/regfile/WB/control), reads EX results
//   slave  : the ID/EX stage itself
interface id_ex_stage_if;
  logic        stall, flush;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [31:0] id_readdat1, id_readdat2;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_regdst, id_alusrc;
  logic [1:0]  id_aluop;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_writedata;

  logic        ex_valid;
  logic [31:0] ex_A, ex_B, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic        hazard_stall, pc_write, ifid_write;
  logic [15:0] bubble_count;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_imm16,
           id_readdat1, id_readdat2, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_alusrc, id_aluop,
           wb_regwrite, wb_rd, wb_writedata,
    input  ex_valid, ex_A, ex_B, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
           ex_aluop, hazard_stall, pc_write, ifid_write, bubble_count
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_imm16,
           id_readdat1, id_readdat2, id_regwrite, id_memread, id_memwrite,
           id_memtoreg, id_regdst, id_alusrc, id_aluop,
           wb_regwrite, wb_rd, wb_writedata,
    output ex_valid, ex_A, ex_B, ex_imm, ex_rs, ex_rt, ex_dest,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
           ex_aluop, hazard_stall, pc_write, ifid_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Captures decoded controls, register operands (with same-cycle WB bypass)
// and the sign-extended immediate; detects load-use hazards and inserts
// bubbles; honours external stall and flush; counts inserted bubbles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - id_ex_stage_if.slave (ID inputs, WB bypass, stall/flush, EX outputs)
module id_ex_stage (
  input logic           clk,
  input logic           rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [1:0] aluop;
  } ctrl_t;

  logic        valid_q, valid_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [15:0] bcnt_q, bcnt_d;

  logic [31:0] opnd_a, opnd_b;
  logic        hazard, bubble;
  ctrl_t       id_ctrl;

  // $zero reads as 0 and is never bypassed; otherwise a WB write to the same
  // register this cycle wins over the stale regfile read.
  function automatic logic [31:0] sel_opnd(input logic [4:0] spec,
                                           input logic [31:0] rf_dat,
                                           input logic wb_we,
                                           input logic [4:0] wb_dst,
                                           input logic [31:0] wb_dat);
    if (spec == 5'd0)                    return 32'd0;
    else if (wb_we && (wb_dst == spec))  return wb_dat;
    else                                 return rf_dat;
  endfunction

  always_comb begin
    opnd_a = sel_opnd(bus.id_rs, bus.id_readdat1, bus.wb_regwrite, bus.wb_rd, bus.wb_writedata);
    opnd_b = sel_opnd(bus.id_rt, bus.id_readdat2, bus.wb_regwrite, bus.wb_rd, bus.wb_writedata);

    hazard = bus.id_valid & valid_q & ctrl_q.memread & (rt_q != 5'd0) &
             ((rt_q == bus.id_rs) | (rt_q == bus.id_rt));
    // flush beats stall; a hazard bubble only lands when not stalled
    bubble = bus.flush | (~bus.stall & hazard);

    id_ctrl = '{regwrite: bus.id_regwrite, memread: bus.id_memread,
                memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                alusrc: bus.id_alusrc, aluop: bus.id_aluop};
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    dest_d  = dest_q;
    bcnt_d  = bcnt_q;
    if (bubble) begin
      // data/specifier registers deliberately hold
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 16'd1;
    end else if (!bus.stall) begin
      valid_d = bus.id_valid;
      ctrl_d  = bus.id_valid ? id_ctrl : '0;
      a_d     = opnd_a;
      b_d     = opnd_b;
      imm_d   = {{16{bus.id_imm16[15]}}, bus.id_imm16};
      rs_d    = bus.id_rs;
      rt_d    = bus.id_rt;
      dest_d  = bus.id_regdst ? bus.id_rd : bus.id_rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      dest_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      dest_q  <= dest_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_A         = a_q;
  assign bus.ex_B         = b_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs        = rs_q;
  assign bus.ex_rt        = rt_q;
  assign bus.ex_dest      = dest_q;
  assign bus.ex_regwrite  = ctrl_q.regwrite;
  assign bus.ex_memread   = ctrl_q.memread;
  assign bus.ex_memwrite  = ctrl_q.memwrite;
  assign bus.ex_memtoreg  = ctrl_q.memtoreg;
  assign bus.ex_alusrc    = ctrl_q.alusrc;
  assign bus.ex_aluop     = ctrl_q.aluop;
  assign bus.hazard_stall = hazard;
  assign bus.pc_write     = ~(hazard | bus.stall);
  assign bus.ifid_write   = ~(hazard | bus.stall);
  assign bus.bubble_count = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_ex_stage_if bus();

  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.id_imm16 = 0;
    bus.id_readdat1 = 0; bus.id_readdat2 = 0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    bus.id_memtoreg = 0; bus.id_regdst = 0; bus.id_alusrc = 0; bus.id_aluop = 0;
    bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_writedata = 0;
  endtask

  task automatic drive_cap();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 4; bus.id_rd = 5;
    bus.id_readdat1 = 32'h11; bus.id_readdat2 = 32'h22; bus.id_imm16 = 16'h8001;
    bus.id_regdst = 1; bus.id_regwrite = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_id();
    #12;
    checks++;
    if ({bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.bubble_count} !== '0) begin
      errors++; $display("FAIL reset_regs: got valid=%0b A=%h B=%h imm=%h cnt=%0d, want all 0",
        bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.bubble_count);
    end
    checks++;
    if ({bus.hazard_stall, bus.pc_write, bus.ifid_write} !== 3'b011) begin
      errors++; $display("FAIL reset_enables: got hz/pc/ifid=%b want 011",
        {bus.hazard_stall, bus.pc_write, bus.ifid_write});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_capture();
    drive_cap();
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.ex_dest, bus.ex_regwrite, bus.ex_rs, bus.ex_rt}
        !== {1'b1, 32'h11, 32'h22, 32'hFFFF8001, 5'd5, 1'b1, 5'd3, 5'd4}) begin
      errors++; $display("FAIL capture: got v=%0b A=%h B=%h imm=%h dest=%0d rw=%0b rs=%0d rt=%0d want 1 11 22 ffff8001 5 1 3 4",
        bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.ex_dest, bus.ex_regwrite, bus.ex_rs, bus.ex_rt);
    end
    // positive immediate, rt as destination, alu controls
    bus.id_imm16 = 16'h7FFF; bus.id_regdst = 0; bus.id_alusrc = 1; bus.id_aluop = 2'b10;
    tick();
    checks++;
    if ({bus.ex_imm, bus.ex_dest, bus.ex_alusrc, bus.ex_aluop} !== {32'h00007FFF, 5'd4, 1'b1, 2'b10}) begin
      errors++; $display("FAIL capture_rt_dest: got imm=%h dest=%0d alusrc=%0b aluop=%b want 00007fff 4 1 10",
        bus.ex_imm, bus.ex_dest, bus.ex_alusrc, bus.ex_aluop);
    end
    // invalid ID instruction: controls gated off, not a bubble
    bus.id_valid = 0;
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.ex_alusrc, bus.ex_aluop, bus.bubble_count} !== {5'b0, 16'd0}) begin
      errors++; $display("FAIL capture_invalid: got v=%0b rw=%0b src=%0b op=%b cnt=%0d want all 0",
        bus.ex_valid, bus.ex_regwrite, bus.ex_alusrc, bus.ex_aluop, bus.bubble_count);
    end
  endtask

  task automatic test_bypass();
    drive_cap();
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_writedata = 32'hDEAD;
    tick();
    checks++;
    if ({bus.ex_A, bus.ex_B} !== {32'hDEAD, 32'h22}) begin
      errors++; $display("FAIL bypass_rs: got A=%h B=%h want dead 22", bus.ex_A, bus.ex_B);
    end
    bus.wb_rd = 4;
    tick();
    checks++;
    if ({bus.ex_A, bus.ex_B} !== {32'h11, 32'hDEAD}) begin
      errors++; $display("FAIL bypass_rt: got A=%h B=%h want 11 dead", bus.ex_A, bus.ex_B);
    end
    bus.wb_rd = 0;
    tick();
    checks++;
    if ({bus.ex_A, bus.ex_B} !== {32'h11, 32'h22}) begin
      errors++; $display("FAIL bypass_wbrd0: got A=%h B=%h want 11 22", bus.ex_A, bus.ex_B);
    end
    bus.wb_rd = 3; bus.wb_regwrite = 0;
    tick();
    checks++;
    if (bus.ex_A !== 32'h11) begin
      errors++; $display("FAIL bypass_nowe: got A=%h want 11", bus.ex_A);
    end
    bus.wb_regwrite = 1; bus.wb_rd = 0; bus.id_rs = 0;
    tick();
    checks++;
    if (bus.ex_A !== 32'h0) begin
      errors++; $display("FAIL bypass_rs0: got A=%h want 0", bus.ex_A);
    end
  endtask

  task automatic test_load_use();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 1; bus.id_rt = 7; bus.id_memread = 1;
    bus.id_memtoreg = 1; bus.id_regwrite = 1; bus.id_alusrc = 1;
    tick();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 7; bus.id_rt = 2; bus.id_rd = 8; bus.id_regdst = 1;
    bus.id_regwrite = 1; bus.id_readdat1 = 32'h77; bus.id_readdat2 = 32'h2;
    #1;
    checks++;
    if ({bus.hazard_stall, bus.pc_write, bus.ifid_write} !== 3'b100) begin
      errors++; $display("FAIL loaduse_detect: got hz/pc/ifid=%b want 100",
        {bus.hazard_stall, bus.pc_write, bus.ifid_write});
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_memread, bus.ex_regwrite, bus.bubble_count, bus.hazard_stall} !== {3'b000, 16'd1, 1'b0}) begin
      errors++; $display("FAIL loaduse_bubble: got v=%0b mr=%0b rw=%0b cnt=%0d hz=%0b want 0 0 0 1 0",
        bus.ex_valid, bus.ex_memread, bus.ex_regwrite, bus.bubble_count, bus.hazard_stall);
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_rs, bus.ex_dest, bus.ex_A, bus.bubble_count} !== {1'b1, 5'd7, 5'd8, 32'h77, 16'd1}) begin
      errors++; $display("FAIL loaduse_capture: got v=%0b rs=%0d dest=%0d A=%h cnt=%0d want 1 7 8 77 1",
        bus.ex_valid, bus.ex_rs, bus.ex_dest, bus.ex_A, bus.bubble_count);
    end
  endtask

  task automatic test_stall_flush();
    drive_cap();
    tick();
    // hold: new ID data and a later WB write must not disturb EX
    bus.stall = 1; bus.id_readdat1 = 32'h99; bus.id_rs = 9;
    bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_writedata = 32'hBEEF;
    #1;
    checks++;
    if ({bus.pc_write, bus.ifid_write} !== 2'b00) begin
      errors++; $display("FAIL stall_enables: got pc/ifid=%b want 00", {bus.pc_write, bus.ifid_write});
    end
    repeat (3) tick();
    checks++;
    if ({bus.ex_valid, bus.ex_A, bus.ex_rs, bus.ex_regwrite, bus.bubble_count} !== {1'b1, 32'h11, 5'd3, 1'b1, 16'd1}) begin
      errors++; $display("FAIL stall_hold: got v=%0b A=%h rs=%0d rw=%0b cnt=%0d want 1 11 3 1 1",
        bus.ex_valid, bus.ex_A, bus.ex_rs, bus.ex_regwrite, bus.bubble_count);
    end
    bus.flush = 1;
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_regwrite, bus.ex_A, bus.bubble_count} !== {2'b00, 32'h11, 16'd2}) begin
      errors++; $display("FAIL stall_flush: got v=%0b rw=%0b A=%h cnt=%0d want 0 0 11 2",
        bus.ex_valid, bus.ex_regwrite, bus.ex_A, bus.bubble_count);
    end
  endtask

  task automatic test_flush_hazard();
    clear_id();
    bus.id_valid = 1; bus.id_rt = 9; bus.id_memread = 1; bus.id_regwrite = 1;
    tick();
    clear_id();
    bus.id_valid = 1; bus.id_rs = 2; bus.id_rt = 9; bus.flush = 1;
    #1;
    checks++;
    if ({bus.hazard_stall, bus.pc_write} !== 2'b10) begin
      errors++; $display("FAIL flushhz_enables: got hz/pc=%b want 10", {bus.hazard_stall, bus.pc_write});
    end
    tick();
    checks++;
    if ({bus.ex_valid, bus.ex_memread, bus.bubble_count} !== {2'b00, 16'd3}) begin
      errors++; $display("FAIL flushhz_once: got v=%0b mr=%0b cnt=%0d want 0 0 3",
        bus.ex_valid, bus.ex_memread, bus.bubble_count);
    end
  endtask

  task automatic test_saturation();
    clear_id();
    bus.flush = 1;
    repeat (65536) @(posedge clk);
    #1;
    checks++;
    if (bus.bubble_count !== 16'hFFFF) begin
      errors++; $display("FAIL saturate: got cnt=%h want ffff", bus.bubble_count);
    end
    tick();
    checks++;
    if (bus.bubble_count !== 16'hFFFF) begin
      errors++; $display("FAIL saturate_hold: got cnt=%h want ffff", bus.bubble_count);
    end
  endtask

  task automatic test_async_reset();
    drive_cap();
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: got v=%0b want 1", bus.ex_valid);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.ex_dest, bus.ex_regwrite, bus.bubble_count, bus.pc_write}
        !== {1'b0, 96'd0, 5'd0, 1'b0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL areset: got v=%0b A=%h B=%h imm=%h dest=%0d rw=%0b cnt=%h pc=%0b want 0s, pc=1",
        bus.ex_valid, bus.ex_A, bus.ex_B, bus.ex_imm, bus.ex_dest, bus.ex_regwrite, bus.bubble_count, bus.pc_write);
    end
    #4 rst = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_capture();
    test_bypass();
    test_load_use();
    test_stall_flush();
    test_flush_hazard();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage pipelined MIPS core. It sits directly downstream of the register file. Each cycle it captures the decoded instruction, the two register-file read operands and the sign-extended immediate into EX-stage registers. It bypasses a same-cycle write-back into the captured operands, detects load-use hazards and inserts bubbles, and handles external stall/flush.

## Interface
- No parameters; datapath fixed at 32 bits, register specifiers at 5 bits.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  external hold (e.g. memory wait); freezes EX registers.
- flush  in  1  branch/jump squash; EX captures a bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- id_imm16  in  16  immediate field.
- id_readdat1, id_readdat2  in  32  register-file read data for rs/rt.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_regdst, id_alusrc  in  1 each  decoded controls.
- id_aluop  in  2  ALU op class.
- wb_regwrite  in  1  WB stage writing the register file this cycle.
- wb_rd  in  5  WB destination.
- wb_writedata  in  32  WB data.
- ex_valid  out  1  EX holds a real instruction.
- ex_A, ex_B  out  32  operands.
- ex_imm  out  32  sign-extended immediate.
- ex_rs, ex_rt  out  5  captured specifiers (for forwarding).
- ex_dest  out  5  destination: id_rd if id_regdst else id_rt.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc  out  1 each; ex_aluop out 2  registered controls.
- hazard_stall  out  1  combinational load-use detect.
- pc_write, ifid_write  out  1 each  upstream enables = ~(hazard_stall | stall).
- bubble_count  out  16  saturating count of inserted bubbles.

## Operation
- Operand select, per port: specifier 0 -> 0; else wb_regwrite & wb_rd==specifier -> wb_writedata; else id_readdat. rs -> A, rt -> B.
- Hazard: hazard_stall = id_valid & ex_valid & ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
- Per-edge priority, highest first:
  - rst: all outputs 0.
  - flush: bubble.
  - stall: hold every EX register and bubble_count.
  - hazard_stall: bubble.
  - else: capture ID.
- Bubble: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop <= 0. Data/specifier registers hold. bubble_count +1.
- Capture: ex_valid <= id_valid. Controls are gated by id_valid (all 0 when id_valid=0). Data, specifiers, ex_imm = {{16{imm16[15]}}, imm16} and ex_dest are loaded.
- bubble_count saturates at 0xFFFF. It increments only on edges where a bubble is inserted (flush or hazard, not under stall). It clears only on rst.

## Timing
- Reset values: every registered output 0 (bubble_count 0, ex_valid 0). Combinational outputs follow their equations; after reset ex_valid=0, so hazard_stall=0 and pc_write=ifid_write=1 when stall=0.
- Latency: one cycle, ID inputs at edge N appear on ex_* after edge N.
- Hazard: exactly one bubble per load-use pair. The edge inserting the bubble clears ex_memread, which drops hazard_stall, so ID is captured on the following edge.
- flush with hazard_stall: bubble (counted once). pc_write/ifid_write still follow hazard_stall.
- flush with stall: flush wins.
- Bypass is combinational on the capture edge only. A WB write on a later cycle does not update held EX operands.
- rst mid-operation clears all state immediately, independent of clk.

## Test plan
- Reset: assert rst asynchronously between edges with ex_valid=1 -> all ex_* and bubble_count go to 0 immediately; pc_write=1.
- Capture: rs=3, rt=4, rd=5, readdat1=0x11, readdat2=0x22, imm16=0x8001, regdst=1, regwrite=1 -> next edge ex_A=0x11, ex_B=0x22, ex_imm=0xFFFF8001, ex_dest=5, ex_regwrite=1.
- Bypass: same as capture plus wb_regwrite=1, wb_rd=3, wb_writedata=0xDEAD -> ex_A=0xDEAD, ex_B=0x22. With wb_rd=0 -> no bypass. With id_rs=0 -> ex_A=0.
- Load-use: lw to rt=7 in EX (memread=1), ID add with rs=7 -> hazard_stall=1, pc_write=0. Next edge ex_valid=0, bubble_count=1. Following edge the add is captured.
- Stall vs flush: stall=1 for 3 cycles -> ex_* held, count unchanged. stall=1 & flush=1 -> bubble, count +1.
- Saturation: force 65536 flushes -> bubble_count stays 0xFFFF.
